// File: rtl/calc3_engine.sv
// Multi-port command engine: per-port two-cycle operand capture, per-port FIFOs,
// and one shared registered ALU serviced by a round-robin arbiter.
module calc3_engine #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 2,
    parameter int unsigned QDEPTH    = 4
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*4-1:0]        req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
    input  logic [NUM_PORTS*TAG_W-1:0]    req_tag_in,
    output logic [NUM_PORTS*2-1:0]        out_resp,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS*TAG_W-1:0]    out_tag,
    output logic [NUM_PORTS-1:0]          drop_err
);

    localparam int unsigned SH_W  = $clog2(DATA_W);
    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_t;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    // ---------------- capture FSMs ----------------
    cap_state_t        cap_state [NUM_PORTS];
    cap_state_t        cap_next  [NUM_PORTS];
    logic [3:0]        cap_cmd   [NUM_PORTS];
    logic [DATA_W-1:0] cap_op1   [NUM_PORTS];
    logic [TAG_W-1:0]  cap_tag   [NUM_PORTS];
    logic [NUM_PORTS-1:0] push;
    entry_t            push_entry [NUM_PORTS];

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            cap_next[p] = cap_state[p];
            push[p]     = 1'b0;
            unique case (cap_state[p])
                CAP_IDLE: if (req_cmd_in[4*p +: 4] != 4'd0) cap_next[p] = CAP_OP2;
                CAP_OP2: begin
                    cap_next[p] = CAP_IDLE;
                    push[p]     = 1'b1;
                end
                default: cap_next[p] = CAP_IDLE;
            endcase
            push_entry[p] = '{cmd: cap_cmd[p], op1: cap_op1[p],
                              op2: req_data_in[DATA_W*p +: DATA_W], tag: cap_tag[p]};
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                cap_state[p] <= CAP_IDLE;
                cap_cmd[p]   <= '0;
                cap_op1[p]   <= '0;
                cap_tag[p]   <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                cap_state[p] <= cap_next[p];
                if (cap_state[p] == CAP_IDLE && req_cmd_in[4*p +: 4] != 4'd0) begin
                    cap_cmd[p] <= req_cmd_in[4*p +: 4];
                    cap_op1[p] <= req_data_in[DATA_W*p +: DATA_W];
                    cap_tag[p] <= req_tag_in[TAG_W*p +: TAG_W];
                end
            end
        end
    end

    // ---------------- per-port queues ----------------
    entry_t               q_mem   [NUM_PORTS][QDEPTH];
    logic [PTR_W-1:0]     wr_ptr  [NUM_PORTS];
    logic [PTR_W-1:0]     rd_ptr  [NUM_PORTS];
    logic [CNT_W-1:0]     q_count [NUM_PORTS];
    logic [NUM_PORTS-1:0] q_nonempty;
    logic [NUM_PORTS-1:0] q_full;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] push_ok;

    // A pop in the same cycle frees the slot, so a full queue still accepts.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            q_nonempty[p] = (q_count[p] != '0);
            q_full[p]     = (q_count[p] == CNT_W'(QDEPTH));
            push_ok[p]    = push[p] && (!q_full[p] || pop[p]);
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                wr_ptr[p]  <= '0;
                rd_ptr[p]  <= '0;
                q_count[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (push_ok[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])     rd_ptr[p] <= rd_ptr[p] + 1'b1;
                if (push_ok[p] && !pop[p])      q_count[p] <= q_count[p] + 1'b1;
                else if (!push_ok[p] && pop[p]) q_count[p] <= q_count[p] - 1'b1;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (push_ok[p]) q_mem[p][wr_ptr[p]] <= push_entry[p];
        end
    end

    // ---------------- round-robin arbiter ----------------
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic          grant_valid;
    int unsigned   cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!grant_valid && q_nonempty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            pop[p] = grant_valid && (grant_idx == PW'(p));
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // ---------------- shared ALU ----------------
    entry_t              head;
    logic [DATA_W:0]     sum;
    logic [SH_W-1:0]     sh;
    logic [2*DATA_W-1:0] rot_l;
    logic [2*DATA_W-1:0] rot_r;
    logic [1:0]          alu_resp;
    logic [DATA_W-1:0]   alu_data;

    // Rotates come from shifting a doubled operand and keeping one half.
    always_comb begin
        head     = q_mem[grant_idx][rd_ptr[grant_idx]];
        sum      = {1'b0, head.op1} + {1'b0, head.op2};
        sh       = head.op2[SH_W-1:0];
        rot_l    = {head.op1, head.op1} << sh;
        rot_r    = {head.op1, head.op1} >> sh;
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (head.cmd)
            OP_ADD: begin
                if (!sum[DATA_W]) begin
                    alu_resp = RESP_OK;
                    alu_data = sum[DATA_W-1:0];
                end
            end
            OP_SUB: begin
                if (head.op2 <= head.op1) begin
                    alu_resp = RESP_OK;
                    alu_data = head.op1 - head.op2;
                end
            end
            OP_SHL: begin
                alu_resp = RESP_OK;
                alu_data = head.op1 << sh;
            end
            OP_SHR: begin
                alu_resp = RESP_OK;
                alu_data = head.op1 >> sh;
            end
            OP_ROL: begin
                alu_resp = RESP_OK;
                alu_data = rot_l[2*DATA_W-1:DATA_W];
            end
            OP_ROR: begin
                alu_resp = RESP_OK;
                alu_data = rot_r[DATA_W-1:0];
            end
            default: begin
                alu_resp = RESP_ERR;
                alu_data = '0;
            end
        endcase
    end

    // ---------------- response registers ----------------
    logic [1:0]           resp_q [NUM_PORTS];
    logic [DATA_W-1:0]    data_q [NUM_PORTS];
    logic [TAG_W-1:0]     tag_q  [NUM_PORTS];
    logic [NUM_PORTS-1:0] drop_q;

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                resp_q[p] <= RESP_NONE;
                data_q[p] <= '0;
                tag_q[p]  <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                resp_q[p] <= RESP_NONE;
                data_q[p] <= '0;
                tag_q[p]  <= '0;
                if (pop[p]) begin
                    resp_q[p] <= alu_resp;
                    data_q[p] <= alu_data;
                    tag_q[p]  <= head.tag;
                end
                if (push[p] && !push_ok[p]) drop_q[p] <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            out_resp[2*p +: 2]          = resp_q[p];
            out_data[DATA_W*p +: DATA_W] = data_q[p];
            out_tag[TAG_W*p +: TAG_W]    = tag_q[p];
        end
        drop_err = drop_q;
    end

endmodule
